// File: rtl/hs_seq_pkg.sv
// Shared types and constants for the HS lane sequencer.
package hs_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LP01,
    S_LP00,
    S_HS_ZERO,
    S_SYNC,
    S_DATA,
    S_TRAIL,
    S_EXIT
  } hs_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // Phase counter walks the four bit pairs of one byte.
  localparam int PH_W = 2;

  function automatic int max5(input int a, input int b, input int c,
                              input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/hs_byte_shifter.sv
// Byte register for the HS serialiser: loads SYNC or payload, shifts out two
// bits per cycle LSB-first, and remembers the MSB of the last loaded byte for
// the trail level. Next-state values are exported so the top level can
// register its serial outputs in step with the FSM.
module hs_byte_shifter
  import hs_seq_pkg::*;
(
  input  logic       TX_DDR_clk,
  input  logic       TX_rst,
  input  logic       load_sync,
  input  logic       load_data,
  input  logic       shift,
  input  logic [7:0] byte_in,
  output logic [1:0] pair_d,
  output logic       trail_lvl_d
);

  logic [7:0] sh_q, sh_d;
  logic       msb_q, msb_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    sh_d  = sh_q;
    msb_d = msb_q;
    if (load_sync) begin
      sh_d  = SYNC_BYTE;
      msb_d = SYNC_BYTE[7];
    end else if (load_data) begin
      sh_d  = byte_in;
      msb_d = byte_in[7];
    end else if (shift) begin
      sh_d = {2'b00, sh_q[7:2]};
    end
  end

  // Shift register and last-MSB storage.
  always_ff @(posedge TX_DDR_clk) begin
    if (TX_rst) begin
      sh_q  <= '0;
      msb_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      msb_q <= msb_d;
    end
  end

  assign pair_d      = sh_d[1:0];
  assign trail_lvl_d = ~msb_d;

endmodule

// File: rtl/hs_lane_sequencer.sv
// HS lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> SYNC -> data ->
// trail -> LP-11 exit. Every output is a flop loaded from the next-state
// decode, so outputs line up with the state they describe and no input
// reaches an output combinationally.
module hs_lane_sequencer
  import hs_seq_pkg::*;
#(
  parameter int LPX_CYC     = 8,
  parameter int PREPARE_CYC = 4,
  parameter int ZERO_CYC    = 12,
  parameter int TRAIL_CYC   = 6,
  parameter int EXIT_CYC    = 8
) (
  input  logic       TX_DDR_clk,
  input  logic       TX_rst,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic       Enable,
  output logic       Serial_B1,
  output logic       Serial_B2,
  output logic       LP_Dp,
  output logic       LP_Dn,
  output logic       HS_Active
);

  localparam int CW = $clog2(max5(LPX_CYC, PREPARE_CYC, ZERO_CYC,
                                  TRAIL_CYC, EXIT_CYC)) + 1;

  hs_state_e       state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [PH_W-1:0] phase, phase_d;
  logic            ld_sync, ld_data, shift;
  logic [1:0]      pair_d;
  logic            trail_lvl_d;
  logic            rdy_d, en_d, b1_d, b2_d, dp_d, dn_d;

  hs_byte_shifter u_shifter (
    .TX_DDR_clk (TX_DDR_clk),
    .TX_rst     (TX_rst),
    .load_sync  (ld_sync),
    .load_data  (ld_data),
    .shift      (shift),
    .byte_in    (TxDataHS),
    .pair_d     (pair_d),
    .trail_lvl_d(trail_lvl_d)
  );

  // Next state, dwell counter and shifter control. Dwells count down from
  // N-1 and leave on zero; the byte handoff is decided at phase 3.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    phase_d = phase;
    ld_sync = 1'b0;
    ld_data = 1'b0;
    shift   = 1'b0;
    unique case (state)
      S_IDLE: if (TxRequestHS) begin
        state_d = S_LP01;
        cnt_d   = CW'(LPX_CYC - 1);
      end
      S_LP01: if (cnt == '0) begin
        state_d = S_LP00;
        cnt_d   = CW'(PREPARE_CYC - 1);
      end else cnt_d = cnt - 1'b1;
      S_LP00: if (cnt == '0) begin
        state_d = S_HS_ZERO;
        cnt_d   = CW'(ZERO_CYC - 1);
      end else cnt_d = cnt - 1'b1;
      S_HS_ZERO: if (cnt == '0) begin
        state_d = S_SYNC;
        phase_d = '0;
        ld_sync = 1'b1;
      end else cnt_d = cnt - 1'b1;
      S_SYNC, S_DATA: if (&phase) begin
        if (TxReadyHS && TxRequestHS) begin
          state_d = S_DATA;
          phase_d = '0;
          ld_data = 1'b1;
        end else begin
          state_d = S_TRAIL;
          cnt_d   = CW'(TRAIL_CYC - 1);
        end
      end else begin
        phase_d = phase + 1'b1;
        shift   = 1'b1;
      end
      S_TRAIL: if (cnt == '0) begin
        state_d = S_EXIT;
        cnt_d   = CW'(EXIT_CYC - 1);
      end else cnt_d = cnt - 1'b1;
      S_EXIT: if (cnt == '0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt - 1'b1;
    endcase
  end

  // Output decode of the upcoming state; the accept strobe is armed for the
  // coming phase-3 cycle only while the source is still requesting.
  always_comb begin
    rdy_d = ((state_d == S_SYNC) || (state_d == S_DATA)) && (&phase_d) && TxRequestHS;
    en_d  = 1'b0;
    b1_d  = 1'b0;
    b2_d  = 1'b0;
    dp_d  = 1'b0;
    dn_d  = 1'b0;
    unique case (state_d)
      S_IDLE, S_EXIT: begin dp_d = 1'b1; dn_d = 1'b1; end
      S_LP01:         dn_d = 1'b1;
      S_LP00:         ;
      S_HS_ZERO:      en_d = 1'b1;
      S_SYNC, S_DATA: begin en_d = 1'b1; b1_d = pair_d[0]; b2_d = pair_d[1]; end
      S_TRAIL:        begin en_d = 1'b1; b1_d = trail_lvl_d; b2_d = trail_lvl_d; end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge TX_DDR_clk) begin
    if (TX_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      phase     <= '0;
      TxReadyHS <= 1'b0;
      Enable    <= 1'b0;
      Serial_B1 <= 1'b0;
      Serial_B2 <= 1'b0;
      LP_Dp     <= 1'b1;
      LP_Dn     <= 1'b1;
      HS_Active <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      phase     <= phase_d;
      TxReadyHS <= rdy_d;
      Enable    <= en_d;
      Serial_B1 <= b1_d;
      Serial_B2 <= b2_d;
      LP_Dp     <= dp_d;
      LP_Dn     <= dn_d;
      HS_Active <= en_d;
    end
  end

endmodule

// File: tb/tb_hs_lane_sequencer.sv
// Bench for hs_lane_sequencer: one instance with default dwells, one with all
// dwells at 1. Stimulus pushes the whole expected per-cycle output trace of a
// burst into a per-instance queue; a forked monitor pops one entry per cycle
// (or expects the idle levels when the queue is empty) and compares.
module tb_hs_lane_sequencer;

  // Packed observation: {rdy, hs_active, enable, dp, dn, b1, b2}
  localparam logic [6:0] IDLE_V = 7'b0001100;
  localparam logic [6:0] LP01_V = 7'b0000100;
  localparam logic [6:0] LP00_V = 7'b0000000;
  localparam logic [6:0] ZERO_V = 7'b0110000;

  logic       clk = 1'b0;
  logic       rst;
  logic       req [2];
  logic [7:0] dat [2];
  logic       rdy [2], en [2], b1 [2], b2 [2], dp [2], dn [2], hsa [2];

  logic [6:0] q0[$], q1[$];
  logic [7:0] bb [8];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  hs_lane_sequencer u_dut0 (
    .TX_DDR_clk(clk), .TX_rst(rst), .TxRequestHS(req[0]), .TxDataHS(dat[0]),
    .TxReadyHS(rdy[0]), .Enable(en[0]), .Serial_B1(b1[0]), .Serial_B2(b2[0]),
    .LP_Dp(dp[0]), .LP_Dn(dn[0]), .HS_Active(hsa[0])
  );

  hs_lane_sequencer #(
    .LPX_CYC(1), .PREPARE_CYC(1), .ZERO_CYC(1), .TRAIL_CYC(1), .EXIT_CYC(1)
  ) u_dut1 (
    .TX_DDR_clk(clk), .TX_rst(rst), .TxRequestHS(req[1]), .TxDataHS(dat[1]),
    .TxReadyHS(rdy[1]), .Enable(en[1]), .Serial_B1(b1[1]), .Serial_B2(b2[1]),
    .LP_Dp(dp[1]), .LP_Dn(dn[1]), .HS_Active(hsa[1])
  );

  // Dwell k (0=lpx,1=prepare,2=zero,3=trail,4=exit) for instance d.
  function automatic int dwell(input int d, input int k);
    int dflt [5] = '{8, 4, 12, 6, 8};
    return (d == 1) ? 1 : dflt[k];
  endfunction

  function automatic int qsize(input int d);
    return (d == 1) ? q1.size() : q0.size();
  endfunction

  task automatic push(input int d, input logic [6:0] v);
    if (d == 1) q1.push_back(v);
    else q0.push_back(v);
  endtask

  // Reference trace of a burst of n bytes (bb[0..n-1]); the source holds the
  // request until the last byte is accepted, so every phase-3 but the last
  // carries an accept strobe.
  task automatic build(input int d, input int n);
    logic [7:0] bv;
    logic       lvl;
    repeat (dwell(d, 0)) push(d, LP01_V);
    repeat (dwell(d, 1)) push(d, LP00_V);
    repeat (dwell(d, 2)) push(d, ZERO_V);
    for (int k = -1; k < n; k++) begin
      bv = (k < 0) ? 8'hB8 : bb[k];
      for (int p = 0; p < 4; p++)
        push(d, {(p == 3 && k < n - 1), 2'b11, 2'b00, bv[2*p], bv[2*p+1]});
    end
    lvl = (n > 0) ? ~bb[n-1][7] : 1'b0;
    repeat (dwell(d, 3)) push(d, {3'b011, 2'b00, lvl, lvl});
    repeat (dwell(d, 4)) push(d, IDLE_V);
  endtask

  task automatic timeout(input string what);
    total++;
    bad++;
    $display("FAIL %s: wait expired, required the event within its budget", what);
  endtask

  task automatic mon_one(input int d);
    logic [6:0] e, a;
    a = {rdy[d], hsa[d], en[d], dp[d], dn[d], b1[d], b2[d]};
    e = IDLE_V;
    if (d == 1) begin
      if (q1.size() > 0) e = q1.pop_front();
    end else begin
      if (q0.size() > 0) e = q0.pop_front();
    end
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL out%0d t=%0t got=%b want=%b (rdy,hsa,en,dp,dn,b1,b2)",
               d, $time, a, e);
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      #1;
      mon_one(0);
      mon_one(1);
    end
  endtask

  // Drive one burst. early=1 raises the request during EXIT, which must be
  // ignored until IDLE (one IDLE cycle precedes LP01).
  task automatic run_burst(input int d, input int n, input bit early);
    int i, cyc;
    cyc = 0;
    if (early) begin
      while (qsize(d) > 2 && cyc < 1000) begin @(negedge clk); cyc++; end
      push(d, IDLE_V);
    end else begin
      while (qsize(d) != 0 && cyc < 1000) begin @(negedge clk); cyc++; end
      @(negedge clk);
    end
    dat[d] = (n > 0) ? bb[0] : 8'h00;
    req[d] = 1'b1;
    build(d, n);
    if (n == 0) begin
      repeat (dwell(d, 0) + dwell(d, 1) + 3) @(negedge clk);
      req[d] = 1'b0;
    end else begin
      i = 0;
      cyc = 0;
      while (i < n && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (rdy[d]) begin
          @(negedge clk);
          i++;
          if (i < n) dat[d] = bb[i];
          else req[d] = 1'b0;
        end
      end
      if (i < n) begin
        req[d] = 1'b0;
        timeout("accept");
      end
    end
  endtask

  initial begin
    int cyc, n;
    rst = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with no request
    repeat (20) @(negedge clk);

    // Single byte 0xA5
    bb[0] = 8'hA5;
    run_burst(0, 1, 1'b0);

    // Back-to-back 0x00, 0xFF, 0x80
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h80;
    run_burst(0, 3, 1'b0);

    // Request dropped during HS_ZERO: SYNC only
    run_burst(0, 0, 1'b0);

    // Reset on the second DATA cycle, then a fresh burst
    cyc = 0;
    while (q0.size() != 0 && cyc < 1000) begin @(negedge clk); cyc++; end
    @(negedge clk);
    bb[0] = 8'h3C;
    dat[0] = bb[0];
    req[0] = 1'b1;
    build(0, 1);
    cyc = 0;
    while (!rdy[0] && cyc < 100) begin @(negedge clk); cyc++; end
    if (!rdy[0]) timeout("sync accept before reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req[0] = 1'b0;
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    bb[0] = 8'($urandom); bb[1] = 8'($urandom);
    run_burst(0, 2, 1'b0);

    // Randomized bursts on the default instance
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) bb[k] = 8'($urandom);
      run_burst(0, n, bit'($urandom_range(0, 1)));
    end

    // Minimum-dwell instance: byte 0x01 gives trail level 1
    bb[0] = 8'h01;
    run_burst(1, 1, 1'b0);
    run_burst(1, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) bb[k] = 8'($urandom);
      run_burst(1, n, 1'b0);
    end

    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (q0.size() != 0 || q1.size() != 0) timeout("drain");
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_lane_sequencer.md
HS_LANE_SEQUENCER -- requirements
Module: hs_lane_sequencer

Interface
REQ-001 The block SHALL have parameter LPX_CYC, default 8, giving the LP-01 dwell in clocks.
REQ-002 The block SHALL have parameter PREPARE_CYC, default 4, giving the LP-00 (HS-prepare) dwell in clocks.
REQ-003 The block SHALL have parameter ZERO_CYC, default 12, giving the HS-zero dwell in clocks.
REQ-004 The block SHALL have parameter TRAIL_CYC, default 6, giving the HS-trail dwell in clocks.
REQ-005 The block SHALL have parameter EXIT_CYC, default 8, giving the LP-11 exit dwell before IDLE in clocks.
REQ-006 TX_DDR_clk  input  1  sole clock; the DDR output stage runs on the same clock.
REQ-007 TX_rst  input  1  reset, synchronous and active-high.
REQ-008 TxRequestHS  input  1  requests an HS burst; held high while bytes remain.
REQ-009 TxDataHS  input  8  payload byte, valid while TxRequestHS is high.
REQ-010 TxReadyHS  output  1  byte-accept strobe; the byte transfers on a cycle with TxReadyHS=1 and TxRequestHS=1.
REQ-011 Enable  output  1  enables the DDR output stage.
REQ-012 Serial_B1  output  1  even bit of the current bit pair, sent on the rising half.
REQ-013 Serial_B2  output  1  odd bit of the current bit pair, sent on the falling half.
REQ-014 LP_Dp, LP_Dn  output  1 each  low-power line levels.
REQ-015 HS_Active  output  1  high from HS_ZERO through TRAIL inclusive.

Function
REQ-016 The FSM SHALL have the states IDLE, LP01, LP00, HS_ZERO, SYNC, DATA, TRAIL and EXIT.
REQ-017 IDLE SHALL drive LP=11 and Enable=0, and SHALL go to LP01 on the first cycle TxRequestHS=1.
REQ-018 LP01 (LP=01) SHALL last LPX_CYC cycles, then the FSM SHALL go to LP00.
REQ-019 LP00 (LP=00, Enable=0) SHALL last PREPARE_CYC cycles, then the FSM SHALL go to HS_ZERO.
REQ-020 HS_ZERO SHALL drive Enable=1 and B1=B2=0 for ZERO_CYC cycles, then the FSM SHALL go to SYNC.
REQ-021 Every byte SHALL be serialised LSB-first over 4 cycles using a phase counter p=0..3, with B1=bit[2p] and B2=bit[2p+1].
REQ-022 SYNC SHALL transmit the constant 0xB8, which gives pairs (B1,B2) = (0,0), (0,1), (1,1), (0,1).
REQ-023 TxReadyHS SHALL be 1 only at p=3 of SYNC and of each DATA byte, and only while TxRequestHS=1.
REQ-024 When a byte is accepted at p=3, that byte SHALL be transmitted starting at p=0 of the next cycle; there SHALL be no gap between bytes.
REQ-025 If TxRequestHS=0 at p=3 of SYNC or of a DATA byte, the FSM SHALL go to TRAIL after that byte completes.
REQ-026 TRAIL SHALL drive B1=B2=~(bit7 of the last transmitted byte), with Enable=1, for TRAIL_CYC cycles; a SYNC-only burst SHALL use ~1=0.
REQ-027 EXIT SHALL drive LP=11 and Enable=0 for EXIT_CYC cycles, then the FSM SHALL go to IDLE.
REQ-028 TxRequestHS SHALL be ignored in EXIT, and IDLE SHALL re-evaluate it on its first cycle.
REQ-029 TxRequestHS dropping during LP01, LP00 or HS_ZERO SHALL NOT abort the sequence; the FSM SHALL continue to SYNC, see no request at p=3, and then TRAIL.
REQ-030 Serial_B1 and Serial_B2 SHALL be 0 whenever Enable=0.
REQ-031 All outputs SHALL be registered, with zero combinational path from inputs to outputs.
REQ-032 The dwell counter SHALL be $clog2(max parameter)+1 bits wide and SHALL reload at each state entry.
REQ-033 A burst of N bytes SHALL take LPX_CYC + PREPARE_CYC + ZERO_CYC + 4(N+1) + TRAIL_CYC + EXIT_CYC cycles from IDLE exit to IDLE.

Reset
REQ-034 While TX_rst is high at a clock edge, the block SHALL set state=IDLE, LP=11, Enable=0, B1=B2=0, TxReadyHS=0, HS_Active=0, and clear all counters.
REQ-035 A reset asserted mid-burst in any state SHALL take effect on that same edge with no trail emitted.

Structure
REQ-036 Package hs_seq_pkg SHALL hold the state enum, SYNC_BYTE=8'hB8, and the phase counter width.
REQ-037 Sub-module hs_byte_shifter SHALL hold the byte register, the load control and the 2-bit-per-cycle shift.
REQ-038 The FSM and counters SHALL stay in the top level.

Verification
REQ-039 Reset, then hold TxRequestHS=0 for 20 cycles -> LP=11, Enable=0, TxReadyHS never asserted.
REQ-040 Send one byte 0xA5 with default parameters -> LP01 for 8 cycles, LP00 for 4, zeros for 12, pairs 00,01,11,01, then 10,10,01,01, then TRAIL B1=B2=0 for 6 cycles, then LP=11 for 8 cycles.
REQ-041 Send 3 back-to-back bytes 0x00, 0xFF, 0x80 -> exactly 3 accept strobes spaced 4 cycles apart, no bit gap, trail level=0.
REQ-042 Drop TxRequestHS during HS_ZERO -> SYNC is sent, no TxReadyHS, TRAIL level=0.
REQ-043 Assert TX_rst on the second cycle of DATA -> on the next edge Enable=0, LP=11, state IDLE; a fresh request then gives a full sequence.
REQ-044 Set parameters to 1,1,1,1,1 and send byte 0x01 -> same ordering with 1-cycle dwells, trail level=1.
